// File: rtl/bp_lite_io_cmd_arbiter.sv
// Round-robin arbiter sharing one BP-lite I/O cmd/resp channel; zero-latency combinational cmd and resp paths.
// Backpressure: the grant locks until downstream yumi, and the tracking FIFO full condition stalls commands.
module bp_lite_io_cmd_arbiter #(
  parameter int num_req_p   = 2,
  parameter int msg_width_p = 512,
  parameter int els_p       = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_yumi_o,
  output logic [msg_width_p-1:0]           req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_ready_i,
  output logic [msg_width_p-1:0]           io_cmd_o,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_yumi_i,
  input  logic [msg_width_p-1:0]           io_resp_i,
  input  logic                             io_resp_v_i,
  output logic                             io_resp_ready_o,
  output logic                             idle_o
);

  localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic [id_width_lp-1:0]  rr_ptr_r, lock_id_r, grant_id, rr_id, idx, head_id;
  logic                    lock_v_r, found, full, nonempty, cmd_v, cmd_acc, resp_acc;
  logic [id_width_lp-1:0]  fifo_r [els_p];
  logic [ptr_width_lp-1:0] rptr_r, wptr_r;
  logic [cnt_width_lp-1:0] count_r;
  logic [num_req_p-1:0][msg_width_p-1:0] cmd_arr;

  assign cmd_arr = req_cmd_i;

  always_comb begin
    rr_id = rr_ptr_r;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = id_width_lp'((int'(rr_ptr_r) + k) % num_req_p);
      if (!found && req_cmd_v_i[idx]) begin
        found = 1'b1;
        rr_id = idx;
      end
    end
  end

  assign grant_id = lock_v_r ? lock_id_r : rr_id;
  assign full     = (count_r == cnt_width_lp'(els_p));
  assign nonempty = (count_r != '0);
  assign cmd_v    = ~full & req_cmd_v_i[grant_id] & (lock_v_r | (|req_cmd_v_i));
  assign cmd_acc  = cmd_v & io_cmd_yumi_i;
  assign head_id  = fifo_r[rptr_r];

  // Outputs are forced quiet while reset is asserted, even though inputs may be active.
  assign io_cmd_v_o      = reset_n_i & cmd_v;
  assign io_cmd_o        = reset_n_i ? cmd_arr[grant_id] : '0;
  assign io_resp_ready_o = reset_n_i & nonempty & req_resp_ready_i[head_id];
  assign req_resp_o      = reset_n_i ? io_resp_i : '0;
  assign resp_acc        = io_resp_v_i & io_resp_ready_o;
  assign idle_o          = ~nonempty & ~lock_v_r;

  always_comb begin
    req_cmd_yumi_o = '0;
    req_resp_v_o   = '0;
    req_cmd_yumi_o[grant_id] = reset_n_i & cmd_acc;
    req_resp_v_o[head_id]    = reset_n_i & io_resp_v_i & nonempty;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r  <= '0;
      lock_v_r  <= 1'b0;
      lock_id_r <= '0;
      rptr_r    <= '0;
      wptr_r    <= '0;
      count_r   <= '0;
    end else begin
      if (cmd_v && !io_cmd_yumi_i) begin
        lock_v_r  <= 1'b1;
        lock_id_r <= grant_id;
      end else if (cmd_acc) begin
        lock_v_r <= 1'b0;
        rr_ptr_r <= (grant_id == id_width_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
      end
      if (cmd_acc)
        wptr_r <= (wptr_r == ptr_width_lp'(els_p - 1)) ? '0 : wptr_r + 1'b1;
      if (resp_acc)
        rptr_r <= (rptr_r == ptr_width_lp'(els_p - 1)) ? '0 : rptr_r + 1'b1;
      case ({cmd_acc, resp_acc})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Requester IDs need no reset: an entry is only read once count_r covers it.
  always_ff @(posedge clk_i) begin
    if (cmd_acc && reset_n_i)
      fifo_r[wptr_r] <= grant_id;
  end

`ifndef SYNTHESIS
  a_cmd_yumi_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(req_cmd_yumi_o));
  a_resp_v_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(req_resp_v_o));
  a_no_resp_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(io_resp_v_i && !nonempty));
  a_lock_holds_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    lock_v_r |-> req_cmd_v_i[lock_id_r]);
`endif

endmodule

// File: doc/bp_lite_io_cmd_arbiter.md
Name: bp_lite_io_cmd_arbiter

Overview:
- Shares one BP-lite I/O command/response channel pair between num_req_p BP-lite requesters, e.g. several AXI-lite-to-BP-lite client bridges plus a debug master.
- Commands are arbitrated round-robin with a grant lock that holds the winner until the downstream accepts.
- Requester IDs of accepted commands are recorded in an in-order tracking FIFO of depth els_p.
- Downstream responses, which return in command order, are routed back to the requester at the FIFO head.
- Sits between the client bridges and the uncached I/O crossbar port.

Parameters:
- num_req_p, 2, number of requesters; legal range 2..8.
- msg_width_p, 512, width of a packed BedRock mem message (cmd and resp).
- els_p, 2, maximum number of outstanding commands; power of two, at least 1.
- id_width_lp, `BSG_SAFE_CLOG2(num_req_p), requester index width (localparam).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- req_cmd_i  in  num_req_p*msg_width_p  per-requester command; requester i occupies slice [i*msg_width_p+:msg_width_p].
- req_cmd_v_i  in  num_req_p  per-requester command valid.
- req_cmd_yumi_o  out  num_req_p  per-requester command accepted; one-hot or zero.
- req_resp_o  out  msg_width_p  response data, broadcast to all requesters.
- req_resp_v_o  out  num_req_p  per-requester response valid; one-hot or zero.
- req_resp_ready_i  in  num_req_p  per-requester response ready.
- io_cmd_o  out  msg_width_p  downstream command.
- io_cmd_v_o  out  1  downstream command valid.
- io_cmd_yumi_i  in  1  downstream accepts command this cycle.
- io_resp_i  in  msg_width_p  downstream response.
- io_resp_v_i  in  1  downstream response valid.
- io_resp_ready_o  out  1  arbiter can take a response.
- idle_o  out  1  no commands outstanding and no grant locked.

Behaviour:
- Reset: asynchronous assertion when reset_n_i=0, synchronous deassertion is the integrator's responsibility. While in reset and on exit, all of the following are 0: rr_ptr_r, lock_v_r, lock_id_r, FIFO read/write pointers and count. During reset all outputs are 0 except idle_o=1.
- Reset mid-transaction drops all tracking. Responses already in flight downstream are the system's responsibility; the arbiter does not replay them.
- Command path, combinational, no added latency:
  - full = (count_r == els_p).
  - When lock_v_r=1, grant_id = lock_id_r.
  - When lock_v_r=0, grant_id = the first i with req_cmd_v_i[i]=1, searching rr_ptr_r, rr_ptr_r+1, ... modulo num_req_p.
  - io_cmd_v_o = ~full & req_cmd_v_i[grant_id] & (lock_v_r | |req_cmd_v_i).
  - io_cmd_o = req_cmd_i slice of grant_id.
  - req_cmd_yumi_o[grant_id] = io_cmd_v_o & io_cmd_yumi_i; all other bits are 0.
- Grant lock:
  - If io_cmd_v_o=1 and io_cmd_yumi_i=0, set lock_v_r=1 and lock_id_r=grant_id on the next edge.
  - On yumi, clear lock_v_r and set rr_ptr_r = (grant_id+1) mod num_req_p, wrapping from num_req_p-1 to 0.
  - Requesters must hold valid and data until yumi. A locked requester that drops valid is a protocol error and is flagged by an assertion.
- Tracking FIFO:
  - On cmd yumi, enqueue grant_id at wptr and increment count.
  - On resp handshake, dequeue and decrement count.
  - Pointers wrap modulo els_p.
  - Enqueue and dequeue in the same cycle leave count unchanged. That case is legal only when count_r < els_p, because enqueue is blocked when full regardless of dequeue.
- Response path, combinational:
  - head_id = fifo[rptr].
  - io_resp_ready_o = (count_r != 0) & req_resp_ready_i[head_id].
  - req_resp_v_o[head_id] = io_resp_v_i & (count_r != 0); all other bits are 0.
  - req_resp_o = io_resp_i.
  - Handshake = io_resp_v_i & io_resp_ready_o.
- Response while empty: io_resp_ready_o=0, the response is never routed, and an assertion fires (simulation only).
- idle_o = (count_r == 0) & ~lock_v_r.
- Stateful elements: rr_ptr_r, lock_v_r, lock_id_r, FIFO storage (els_p x id_width_lp), rptr, wptr, count (width clog2(els_p+1)).
- Assertions, translate_off: req_cmd_yumi_o one-hot-or-zero; req_resp_v_o one-hot-or-zero; no response while empty; locked requester keeps valid asserted.

Test Plan:
- Reset: hold reset_n_i=0 while driving all valids high -> all yumi/valid outputs 0 and idle_o=1; release reset -> first grant goes to requester 0.
- Round-robin: num_req_p=2, both valid every cycle, io_cmd_yumi_i=1, els_p large enough, responses returned each cycle -> yumi sequence 0,1,0,1; responses routed 0,1,0,1.
- Lock: requester 1 valid with downstream yumi=0 for 3 cycles, requester 0 asserts valid in cycle 2 -> io_cmd_o stays requester 1's data for all 3 cycles; yumi goes to 1; next grant goes to 0.
- Full: els_p=2, two commands accepted, no responses -> io_cmd_v_o=0 despite a pending valid. One response returned -> count=1 and the next command is accepted the following cycle; same-cycle enqueue/dequeue at count=1 keeps count=1.
- Response backpressure: head_id=1 with req_resp_ready_i[1]=0 for 4 cycles and req_resp_ready_i[0]=1 -> io_resp_ready_o=0 and req_resp_v_o=2'b10 held; ready rises -> dequeue and routing of exactly one response.
- Async reset mid-operation: two commands outstanding and lock set, pulse reset_n_i low between clock edges -> outputs drop immediately; after release idle_o=1 and rr_ptr_r=0.
